// File: rtl/serial_byte_loader.sv
// Serial-to-parallel feeder for an enable-gated register: shifts in WIDTH qualified bits, then strobes load_en with the word.
// Optional even-parity trailer bit when PARITY_CHECK_EN is defined.
module serial_byte_loader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic             sin_valid,
  input  logic             sin_bit,
  output logic [WIDTH-1:0] data_out,
  output logic             load_en,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    LOAD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted_s;

`ifdef PARITY_CHECK_EN
  logic             perr_q, perr_d;

  // Even parity: data bits XOR parity bit must be zero.
  function automatic logic even_parity_bad(input logic [WIDTH-1:0] word, input logic par);
    return (^word) ^ par;
  endfunction
`endif

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    overrun_d = overrun_q;
`ifdef PARITY_CHECK_EN
    perr_d    = 1'b0;
`endif
    if (MSB_FIRST) begin
      shifted_s = {sreg_q[WIDTH-2:0], sin_bit};
    end else begin
      shifted_s = {sin_bit, sreg_q[WIDTH-1:1]};
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = {CW{1'b0}};
          sreg_d  = {WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // A start mid-frame restarts the frame and drops any bit offered alongside it.
        if (start) begin
          overrun_d = 1'b1;
          cnt_d     = {CW{1'b0}};
          sreg_d    = {WIDTH{1'b0}};
        end else if (sin_valid) begin
          sreg_d = shifted_s;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d = CW'(WIDTH);
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = LOAD;
`endif
          end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = SHIFT;
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (start) begin
          overrun_d = 1'b1;
          cnt_d     = {CW{1'b0}};
          sreg_d    = {WIDTH{1'b0}};
          state_d   = SHIFT;
        end else if (sin_valid) begin
          if (even_parity_bad(sreg_q, sin_bit)) begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = PARITY;
        end
      end
`endif
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    load_d = (state_d == LOAD);
    if (load_d) begin
      data_d = sreg_d;
    end else begin
      data_d = data_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      sreg_q    <= {WIDTH{1'b0}};
      data_q    <= {WIDTH{1'b0}};
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      data_q    <= data_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_out = data_q;
  assign load_en  = load_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
// Self-checking bench: MSB-first and LSB-first instances share one serial stream; a scoreboard queue per instance
// holds the expected word for every frame, popped when load_en is seen.
module tb_serial_byte_loader;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       start = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_bit = 1'b0;
  logic [7:0] data_m, data_l;
  logic       load_m, load_l, busy_m, busy_l, ovr_m, ovr_l, perr_m, perr_l;

  int checks = 0;
  int failures = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  int perr_expected = 0;
  int perr_seen = 0;

  always #5 clk = ~clk;

  serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_(rst_), .start(start), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .data_out(data_m), .load_en(load_m), .busy(busy_m), .overrun(ovr_m), .parity_err(perr_m)
  );

  serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_(rst_), .start(start), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .data_out(data_l), .load_en(load_l), .busy(busy_l), .overrun(ovr_l), .parity_err(perr_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bit_rev(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin_valid = 1'b1;
    sin_bit   = b;
    tick();
    sin_valid = 1'b0;
    sin_bit   = 1'b0;
  endtask

  // Bits go out w[7] first; the MSB-first instance rebuilds w, the LSB-first one its bit reverse.
  task automatic send_frame(input logic [7:0] w, input bit gapped, input bit bad_par);
`ifdef PARITY_CHECK_EN
    if (!bad_par) begin
      q_m.push_back(w);
      q_l.push_back(bit_rev(w));
    end else begin
      perr_expected++;
    end
`else
    q_m.push_back(w);
    q_l.push_back(bit_rev(w));
`endif
    start = 1'b1;
    sin_valid = 1'b1;
    sin_bit = 1'b1;
    tick();
    start = 1'b0;
    sin_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (gapped) begin
        repeat ($urandom_range(3, 1)) begin
          sin_bit = ~w[i];
          tick();
          check_eq("busy_gap", {30'd0, busy_m, busy_l}, 32'h3);
          check_eq("no_early_load", {30'd0, load_m, load_l}, 32'h0);
        end
      end
      send_bit(w[i]);
    end
`ifdef PARITY_CHECK_EN
    send_bit((^w) ^ bad_par);
`endif
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
  endtask

  task automatic check_idle_reset(input string tag);
    check_eq({tag, "_data"}, {16'd0, data_m, data_l}, 32'h0);
    check_eq({tag, "_load"}, {30'd0, load_m, load_l}, 32'h0);
    check_eq({tag, "_busy"}, {30'd0, busy_m, busy_l}, 32'h0);
    check_eq({tag, "_ovr"},  {30'd0, ovr_m, ovr_l}, 32'h0);
    check_eq({tag, "_perr"}, {30'd0, perr_m, perr_l}, 32'h0);
  endtask

  // Scoreboard: every load_en cycle must match the oldest expected word.
  always @(negedge clk) begin
    if (load_m) begin
      if (q_m.size() == 0) check_eq("load_m_unexpected", 32'd1, 32'd0);
      else check_eq("data_m", {24'd0, data_m}, {24'd0, q_m.pop_front()});
    end
    if (load_l) begin
      if (q_l.size() == 0) check_eq("load_l_unexpected", 32'd1, 32'd0);
      else check_eq("data_l", {24'd0, data_l}, {24'd0, q_l.pop_front()});
    end
    if (perr_m) perr_seen++;
  end

  initial begin
    do_reset();
    check_idle_reset("reset");

    // Normal frame, consecutive bits.
    send_frame(8'hA5, 1'b0, 1'b0);
    check_eq("t1_load_now", {30'd0, load_m, load_l}, 32'h3);
    tick();
    check_eq("t1_load_one_cycle", {30'd0, load_m, load_l}, 32'h0);
    check_eq("t1_hold", {16'd0, data_m, data_l}, {16'd0, 8'hA5, 8'hA5});
    check_eq("t1_busy_low", {30'd0, busy_m, busy_l}, 32'h0);

    // Gapped frame.
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (2) tick();

    // Bits 1,0,1,0,0,0,0,0: LSB-first instance must produce 8'h05.
    send_frame(8'hA0, 1'b0, 1'b0);
    tick();
    check_eq("t5_lsb", {24'd0, data_l}, 32'h05);
    check_eq("t5_msb", {24'd0, data_m}, 32'hA0);
    check_eq("no_overrun_yet", {30'd0, ovr_m, ovr_l}, 32'h0);

`ifdef PARITY_CHECK_EN
    send_frame(8'hA5, 1'b0, 1'b0);
    tick();
    check_eq("t6_good", {24'd0, data_m}, 32'hA5);
    send_frame(8'hA5, 1'b0, 1'b1);
    check_eq("t6_perr", {30'd0, perr_m, perr_l}, 32'h3);
    check_eq("t6_no_load", {30'd0, load_m, load_l}, 32'h0);
    check_eq("t6_data_kept", {24'd0, data_m}, 32'hA5);
    tick();
    check_eq("t6_perr_pulse", {30'd0, perr_m, perr_l}, 32'h0);
`endif

    // Overrun: restart after 4 bits, then a full 8'h3C frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check_eq("t3_busy", {30'd0, busy_m, busy_l}, 32'h3);
    send_frame(8'h3C, 1'b0, 1'b0);
    check_eq("t3_ovr", {30'd0, ovr_m, ovr_l}, 32'h3);
    repeat (2) tick();
    send_frame(8'h96, 1'b1, 1'b0);
    repeat (2) tick();
    check_eq("t3_ovr_sticky", {30'd0, ovr_m, ovr_l}, 32'h3);

    // Reset mid-frame after 5 bits.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    do_reset();
    check_idle_reset("t4_after_rst");
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    check_eq("t4_idle_ignores", {30'd0, busy_m, load_m}, 32'h0);
    send_frame(8'h0F, 1'b0, 1'b0);
    tick();
    check_eq("t4_data", {16'd0, data_m, data_l}, {16'd0, 8'h0F, 8'hF0});

    repeat (3) tick();
    check_eq("q_m_drained", q_m.size(), 32'd0);
    check_eq("q_l_drained", q_l.size(), 32'd0);
    check_eq("perr_count", perr_seen, perr_expected);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
